// File: rtl/i2c_slave_responder.sv
// I2C target with a small register file: byte writes land at an auto-incrementing
// pointer (first data byte loads the pointer), reads stream reg[ptr] out MSB first.
// All bus inputs are resynchronized to PCLK. SCL edges and START/STOP are detected
// on the synchronized copies.
`timescale 1ns/1ps
module i2c_slave_responder #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         NUM_REGS   = 8
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic                        scl_i,
    input  logic                        sda_i,
    output logic                        sda_oe,
    output logic                        busy,
    output logic                        wr_valid,
    output logic [$clog2(NUM_REGS)-1:0] wr_addr,
    output logic [7:0]                  wr_data
);
    localparam int PW = $clog2(NUM_REGS);

    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_ADDR, RX_BYTE, ACK_RX, TX_BYTE, ACK_TX, WAIT_STOP
    } state_t;

    logic [1:0]    scl_sync, sda_sync;
    logic          scl_d, sda_d;
    logic          scl_s, sda_s;
    logic          scl_rise, scl_fall, start_det, stop_det;

    state_t        state;
    logic [2:0]    bit_cnt;
    logic [6:0]    shreg;
    logic [7:0]    rx_byte;
    logic [7:0]    tx_sh;
    logic          tx_load;
    logic          rw;
    logic          first_byte;
    logic [PW-1:0] ptr;
    logic [7:0]    regs [NUM_REGS];

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // START/STOP only count while SCL has been stably high for two samples
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rx_byte   = {shreg, sda_s};

    // Two-flop synchronizers plus one history flop for edge detection; idle bus level is 1
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    // Protocol FSM; sda_oe is only updated on SCL falls (or START/STOP, when it is released)
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            tx_sh      <= 8'd0;
            tx_load    <= 1'b0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            ptr        <= '0;
            sda_oe     <= 1'b0;
            busy       <= 1'b0;
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'd0;
        end else begin
            wr_valid <= 1'b0;
            if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
                sda_oe  <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    IDLE, WAIT_STOP: ;
                    ADDR: if (scl_rise) begin
                        shreg   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            rw <= sda_s;
                            if (shreg == SLAVE_ADDR) begin
                                state <= ACK_ADDR;
                                busy  <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    // First fall pulls SDA for the ACK clock, second fall ends it.
                    // sda_oe itself tells the two falls apart.
                    ACK_ADDR: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            bit_cnt <= 3'd0;
                            if (rw) begin
                                state   <= TX_BYTE;
                                tx_load <= 1'b0;
                                sda_oe  <= ~regs[ptr][7];
                                tx_sh   <= {regs[ptr][6:0], 1'b0};
                            end else begin
                                state      <= RX_BYTE;
                                first_byte <= 1'b1;
                                sda_oe     <= 1'b0;
                            end
                        end
                    end
                    RX_BYTE: if (scl_rise) begin
                        shreg   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= ACK_RX;
                            if (first_byte) begin
                                first_byte <= 1'b0;
                                ptr        <= rx_byte[PW-1:0];
                            end else begin
                                regs[ptr] <= rx_byte;
                                wr_valid  <= 1'b1;
                                wr_addr   <= ptr;
                                wr_data   <= rx_byte;
                                ptr       <= ptr + 1'b1;
                            end
                        end
                    end
                    ACK_RX: if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe <= 1'b1;
                        end else begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 3'd0;
                            state   <= RX_BYTE;
                        end
                    end
                    // After a master ACK the next byte is fetched on the following fall,
                    // so the incremented pointer is already in place.
                    TX_BYTE: begin
                        if (scl_fall) begin
                            if (tx_load) begin
                                tx_load <= 1'b0;
                                sda_oe  <= ~regs[ptr][7];
                                tx_sh   <= {regs[ptr][6:0], 1'b0};
                            end else begin
                                sda_oe <= ~tx_sh[7];
                                tx_sh  <= {tx_sh[6:0], 1'b0};
                            end
                        end
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= ACK_TX;
                        end
                    end
                    ACK_TX: begin
                        if (scl_fall) sda_oe <= 1'b0;
                        if (scl_rise) begin
                            if (!sda_s) begin
                                ptr     <= ptr + 1'b1;
                                tx_load <= 1'b1;
                                bit_cnt <= 3'd0;
                                state   <= TX_BYTE;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench for i2c_slave_responder: a bit-banged I2C master with a byte-level model of
// the target (register array, pointer, addressed mode) that predicts SDA drive, busy
// and the write pulses.
`timescale 1ns/1ps
module tb_i2c_slave_responder;
    localparam logic [6:0] SA = 7'h50;
    localparam int         NR = 8;

    logic       PCLK = 1'b0;
    logic       PRESETn = 1'b0;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       scl_i, sda_i;
    logic       sda_oe, busy, wr_valid;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;

    assign scl_i = scl_m;
    assign sda_i = sda_m & ~sda_oe;

    i2c_slave_responder #(.SLAVE_ADDR(SA), .NUM_REGS(NR)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .scl_i(scl_i), .sda_i(sda_i),
        .sda_oe(sda_oe), .busy(busy), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 PCLK = ~PCLK;

    int n_chk = 0, n_fail = 0;

    typedef enum {M_IDLE, M_WR, M_RD, M_IGN} mmode_t;
    mmode_t     mmode = M_IDLE;
    logic [7:0] mreg [NR];
    int         mptr = 0;
    bit         mfirst = 0;
    logic       exp_oe = 1'b0, exp_busy = 1'b0;
    bit         chk_en = 0;
    int         exp_q[$], got_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: during the settled part of each SCL high phase
    always @(negedge PCLK) begin
        if (chk_en) begin
            chk("sda_oe", 32'(sda_oe), 32'(exp_oe));
            chk("busy", 32'(busy), 32'(exp_busy));
        end
    end

    // Record every write pulse (one entry per high cycle)
    always @(negedge PCLK) begin
        if (PRESETn && wr_valid) got_q.push_back(int'(wr_addr) * 256 + int'(wr_data));
    end

    // One SCL clock, entered and left just after SCL falls
    task automatic clk_bit(input logic mb, input logic eo, output logic rb);
        exp_oe = eo;
        #60 sda_m = mb;
        #60 scl_m = 1'b1;
        #50 chk_en = 1;
        #30 rb = sda_i;
        #30 chk_en = 0;
        #10 scl_m = 1'b0;
    endtask

    task automatic do_start();
        sda_m = 1'b0;
        #60 scl_m = 1'b0;
        mmode = M_IDLE; exp_busy = 1'b0;
    endtask

    task automatic do_rstart();
        #60 sda_m = 1'b1;
        #60 scl_m = 1'b1;
        #60 sda_m = 1'b0;
        #60 scl_m = 1'b0;
        mmode = M_IDLE; exp_busy = 1'b0;
    endtask

    task automatic do_stop();
        #60 sda_m = 1'b0;
        #60 scl_m = 1'b1;
        #60 sda_m = 1'b1;
        #120;
        mmode = M_IDLE; exp_busy = 1'b0;
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("sda_oe_after_stop", 32'(sda_oe), 32'd0);
    endtask

    task automatic m_write_byte(input logic [7:0] b, input bit is_addr);
        logic r, ack, match;
        match = (b[7:1] == SA);
        for (int i = 7; i >= 0; i--) begin
            if (is_addr && i == 0) exp_busy = match;
            clk_bit(b[i], 1'b0, r);
        end
        ack = is_addr ? match : (mmode == M_WR);
        clk_bit(1'b1, ack, r);
        if (is_addr) begin
            mmode  = !match ? M_IGN : (b[0] ? M_RD : M_WR);
            mfirst = 1;
        end else if (mmode == M_WR) begin
            if (mfirst) begin
                mptr = int'(b) % NR; mfirst = 0;
            end else begin
                exp_q.push_back(mptr * 256 + int'(b));
                mreg[mptr] = b;
                mptr = (mptr + 1) % NR;
            end
        end
    endtask

    task automatic m_read_byte(input bit mack, output logic [7:0] got);
        logic [7:0] e;
        logic r;
        bit act;
        act = (mmode == M_RD);
        e = act ? mreg[mptr] : 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            clk_bit(1'b1, act ? ~e[i] : 1'b0, r);
            got[i] = r;
        end
        chk("read_byte", 32'(got), 32'(e));
        clk_bit(mack ? 1'b0 : 1'b1, 1'b0, r);
        if (act) begin
            if (mack) mptr = (mptr + 1) % NR;
            else      mmode = M_IGN;
        end
    endtask

    task automatic rd_burst(input int n);
        logic [7:0] g;
        for (int k = 0; k < n; k++) m_read_byte(k != n - 1, g);
    endtask

    task automatic check_writes(input string name);
        chk({name, "_wr_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({name, "_wr_entry"}, 32'(got_q[i]), 32'(exp_q[i]));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [7:0] g;
        logic       r;
        int         n;
        logic [6:0] a;
        bit         rw;

        for (int i = 0; i < NR; i++) mreg[i] = 8'h00;

        // Reset state
        #33;
        chk("rst_sda_oe", 32'(sda_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        #40 PRESETn = 1'b1;
        #100;
        chk("idle_busy", 32'(busy), 32'd0);

        // Write: START A0 03 5A C3 STOP
        do_start();
        m_write_byte(8'hA0, 1); m_write_byte(8'h03, 0);
        m_write_byte(8'h5A, 0); m_write_byte(8'hC3, 0);
        do_stop();
        chk("write_n_pulses", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            chk("write_pulse0", 32'(got_q[0]), 32'h35A);
            chk("write_pulse1", 32'(got_q[1]), 32'h4C3);
        end
        check_writes("write");

        // Read: START A0 03 rSTART A1, ACK then NACK
        do_start();
        m_write_byte(8'hA0, 1); m_write_byte(8'h03, 0);
        do_rstart();
        m_write_byte(8'hA1, 1);
        m_read_byte(1, g); chk("read_lit0", 32'(g), 32'h5A);
        m_read_byte(0, g); chk("read_lit1", 32'(g), 32'hC3);
        do_stop();
        check_writes("read");

        // Address mismatch: no ACK, nothing written, busy stays low
        do_start();
        m_write_byte(8'h42, 1); m_write_byte(8'h99, 0);
        do_stop();
        check_writes("mismatch");

        // Pointer wrap, with reg[1] preloaded so the final pointer shows up on read
        do_start(); m_write_byte(8'hA0, 1); m_write_byte(8'h01, 0); m_write_byte(8'h77, 0); do_stop();
        do_start(); m_write_byte(8'hA0, 1); m_write_byte(8'h07, 0);
        m_write_byte(8'h11, 0); m_write_byte(8'h22, 0); do_stop();
        chk("wrap_n_pulses", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chk("wrap_pulse1", 32'(got_q[1]), 32'h711);
            chk("wrap_pulse2", 32'(got_q[2]), 32'h022);
        end
        check_writes("wrap");
        do_start(); m_write_byte(8'hA1, 1); m_read_byte(0, g); do_stop();
        chk("wrap_ptr_is_1", 32'(g), 32'h77);
        do_start(); m_write_byte(8'hA0, 1); m_write_byte(8'h07, 0); do_rstart();
        m_write_byte(8'hA1, 1);
        m_read_byte(1, g); chk("wrap_reg7", 32'(g), 32'h11);
        m_read_byte(0, g); chk("wrap_reg0", 32'(g), 32'h22);
        do_stop();

        // Early STOP after 4 data bits
        do_start(); m_write_byte(8'hA0, 1); m_write_byte(8'h05, 0);
        for (int i = 0; i < 4; i++) clk_bit(1'(i & 1), 1'b0, r);
        do_stop();
        check_writes("early_stop");

        // Randomized transactions
        for (int t = 0; t < 16; t++) begin
            do_start();
            a  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SA;
            rw = 1'($urandom_range(0, 1));
            m_write_byte({a, rw}, 1);
            if (!rw) begin
                n = $urandom_range(1, 3);
                for (int k = 0; k < n; k++) m_write_byte(8'($urandom), 0);
                if ($urandom_range(0, 1) == 1) begin
                    do_rstart();
                    m_write_byte({SA, 1'b1}, 1);
                    rd_burst($urandom_range(1, 3));
                end
            end else begin
                rd_burst($urandom_range(1, 3));
            end
            do_stop();
            check_writes("rand");
        end

        // Reset while the target pulls SDA low for a 0 data bit
        do_start(); m_write_byte(8'hA0, 1); m_write_byte(8'h02, 0); m_write_byte(8'h3C, 0); do_stop();
        check_writes("pre_reset");
        do_start(); m_write_byte(8'hA0, 1); m_write_byte(8'h02, 0); do_rstart();
        m_write_byte(8'hA1, 1);
        #60 sda_m = 1'b1;
        #60 scl_m = 1'b1;
        #50 chk("tx_bit_driven", 32'(sda_oe), 32'd1);
        @(posedge PCLK);
        #2 PRESETn = 1'b0;
        #1 chk("async_release", 32'(sda_oe), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NR; i++) mreg[i] = 8'h00;
        mptr = 0; mmode = M_IDLE; exp_busy = 1'b0;
        #20 scl_m = 1'b0;
        #60 PRESETn = 1'b1;
        // Leftover clocks without a START must be ignored
        for (int i = 0; i < 9; i++) clk_bit(1'($urandom_range(0, 1)), 1'b0, r);
        do_stop();
        check_writes("post_reset");
        do_start(); m_write_byte(8'hA1, 1);
        m_read_byte(1, g); chk("reset_reg0", 32'(g), 32'h00);
        m_read_byte(0, g); chk("reset_reg1", 32'(g), 32'h00);
        do_stop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
